uart_core: RTL and testbench

// - Full-duplex asynchronous serial port: 8N1 framing (default), LSB first, idle-high line.
// - Runs on a single clock at OVERSAMPLE x baud (e.g. 10 x 115200 from a divider upstream).
// - Receive side delivers words via rcvd/rxack level handshake; transmit side accepts words via start/ready.
// - Sits between board pins (rx/tx) and a byte-level client such as a loopback or command parser.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rx.sv | 105 ++++++++++
 rtl/uart_tx.sv | 86 ++++++++
 rtl/uart_core.sv | 41 ++++
 tb/tb_uart_core.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8N1 UART core.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OVERSAMPLE = 10;

  // Literals are prefixed so both FSM enums can live in one package scope.
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled frame FSM and
// the rcvd/rx_err/rxack client handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  rxack,
  output logic [DATA_WIDTH-1:0] datarx,
  output logic                  rcvd,
  output logic                  rx_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  logic [1:0]            sync;
  logic                  rx_s;
  logic                  rx_prev;
  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      datarx  <= '0;
      rcvd    <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      // Ack clears the pending word; a store in STOP below overrides it.
      if (rxack && rcvd) begin
        rcvd   <= 1'b0;
        rx_err <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            // Mid stop bit: deliver and return to IDLE so a start edge
            // right at the end of this stop bit is still caught.
            cnt    <= '0;
            datarx <= shreg;
            rcvd   <= 1'b1;
            rx_err <= ~rx_s | rcvd;
            state  <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start/ready accept, LSB-first shifter, registered tx.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] datatx,
  input  logic                  start,
  output logic                  ready,
  output logic                  tx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ready   <= 1'b1;
      tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (start) begin
            shreg <= datatx;
            ready <= 1'b0;
            tx    <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= TX_STOP;
            end else begin
              // tx takes the next bit while the shifter advances under it.
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            ready <= 1'b1;
            state <= TX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent receiver and transmitter on one
// oversample clock.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  tx,
  output logic [DATA_WIDTH-1:0] datarx,
  output logic                  rcvd,
  output logic                  rx_err,
  input  logic                  rxack,
  input  logic [DATA_WIDTH-1:0] datatx,
  input  logic                  start,
  output logic                  ready
);

  uart_rx #(.DATA_WIDTH(DATA_WIDTH), .OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .rxack  (rxack),
    .datarx (datarx),
    .rcvd   (rcvd),
    .rx_err (rx_err)
  );

  uart_tx #(.DATA_WIDTH(DATA_WIDTH), .OVERSAMPLE(OVERSAMPLE)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .datatx (datatx),
    .start  (start),
    .ready  (ready),
    .tx     (tx)
  );

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: expected RX words and TX frames are queued
// by the stimulus and consumed by independent RX/TX monitors.
module tb_uart_core;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } rx_exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       tx;
  logic [7:0] datarx;
  logic       rcvd;
  logic       rx_err;
  logic       rxack = 1'b0;
  logic [7:0] datatx = 8'h00;
  logic       start = 1'b0;
  logic       ready;
  logic       auto_ack = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  rx_exp_t    rx_q[$];
  logic [9:0] tx_q[$];

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_core #(.DATA_WIDTH(8), .OVERSAMPLE(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx_line),
    .tx     (tx),
    .datarx (datarx),
    .rcvd   (rcvd),
    .rx_err (rx_err),
    .rxack  (rxack),
    .datatx (datatx),
    .start  (start),
    .ready  (ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bit-time driver; bit_ns of 100 is nominal, 99/101 give +-1% skew.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx_drv = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      #(bit_ns);
    end
    rx_drv = stop_bit;
    #(bit_ns);
    rx_drv = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int t;
    t = 0;
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("tx_ready_before_start", {31'd0, ready}, 32'd1);
    datatx = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
  endtask

  // RX monitor: a new word is announced by rcvd rising.
  initial begin : rx_mon
    rx_exp_t e;
    logic    prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rcvd && !prev) begin
        if (rx_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: got word 0x%0h, want no word", datarx);
        end else begin
          e = rx_q.pop_front();
          chk("rx_data", {24'd0, datarx}, {24'd0, e.d});
          chk("rx_err", {31'd0, rx_err}, {31'd0, e.e});
        end
      end
      if (rcvd && auto_ack) begin
        rxack = 1'b1;
        @(negedge clk);
        chk("rx_ack_clear", {31'd0, rcvd}, 32'd0);
        rxack = 1'b0;
      end
      prev = rcvd;
    end
  end

  // TX monitor: decodes the line at mid-bit; frames cut by reset are dropped.
  initial begin : tx_mon
    logic [9:0] fr;
    logic [9:0] e;
    logic       ab;
    @(posedge reset);
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        ab = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!reset) ab = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
          fr[i] = tx;
          if (i < 9) begin
            repeat (10) begin
              @(negedge clk);
              if (!reset) ab = 1'b1;
            end
          end
        end
        if (!ab) begin
          if (tx_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_unexpected: got frame 0x%0h, want no frame", fr);
          end else begin
            e = tx_q.pop_front();
            chk("tx_frame", {22'd0, fr}, {22'd0, e});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish by 400us, want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  logic [7:0] lb_byte[3]  = '{8'h00, 8'hFF, 8'h80};
  logic [9:0] lb_frame[3] = '{10'h200, 10'h3FE, 10'h300};
  int         skew_ns[2]  = '{101, 99};

  initial begin : stim
    int cnt;

    // Reset values while reset is held low.
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rcvd", {31'd0, rcvd}, 32'd0);
    chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
    chk("rst_datarx", {24'd0, datarx}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // TX 0xA5: line 0,1,0,1,0,0,1,0,1,1 -> frame {stop,data,start} = 0x34A.
    tx_q.push_back(10'h34A);
    datatx = 8'hA5;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    datatx = 8'hFF;
    cnt = 0;
    while (!ready && cnt < 200) begin
      cnt++;
      if (cnt == 40) start = 1'b1;
      if (cnt == 41) start = 1'b0;
      @(negedge clk);
    end
    chk("tx_ready_low_clks", cnt, 32'd100);
    repeat (30) @(negedge clk);
    chk("tx_no_queued_start_ready", {31'd0, ready}, 32'd1);
    chk("tx_no_queued_start_line", {31'd0, tx}, 32'd1);

    // RX 0x3C, clean frame.
    rx_q.push_back({8'h3C, 1'b0});
    send_rx(8'h3C, 1'b1, 100);
    repeat (15) @(negedge clk);

    // RX framing error: 0x55 with stop bit low.
    rx_q.push_back({8'h55, 1'b1});
    send_rx(8'h55, 1'b0, 100);
    repeat (15) @(negedge clk);

    // Glitch: 3 clks low is rejected at the start-bit re-sample.
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_no_rcvd", {31'd0, rcvd}, 32'd0);

    // Overrun: 0x11 then 0x22 back-to-back with no ack.
    auto_ack = 1'b0;
    rx_q.push_back({8'h11, 1'b0});
    send_rx(8'h11, 1'b1, 100);
    send_rx(8'h22, 1'b1, 100);
    repeat (10) @(negedge clk);
    chk("ovr_datarx", {24'd0, datarx}, 32'h22);
    chk("ovr_rx_err", {31'd0, rx_err}, 32'd1);
    chk("ovr_rcvd", {31'd0, rcvd}, 32'd1);
    auto_ack = 1'b1;
    cnt = 0;
    while (rcvd && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("ovr_cleared_rcvd", {31'd0, rcvd}, 32'd0);
    chk("ovr_cleared_err", {31'd0, rx_err}, 32'd0);

    // Reset mid-TX-frame with a word pending on RX.
    auto_ack = 1'b0;
    rx_q.push_back({8'h77, 1'b0});
    send_rx(8'h77, 1'b1, 100);
    repeat (10) @(negedge clk);
    send_tx(8'h5A);
    repeat (30) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_rcvd", {31'd0, rcvd}, 32'd0);
    chk("midrst_rx_err", {31'd0, rx_err}, 32'd0);
    chk("midrst_datarx", {24'd0, datarx}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    auto_ack = 1'b1;
    repeat (120) @(negedge clk);

    // Loopback tx -> rx.
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(lb_frame[i]);
      rx_q.push_back({lb_byte[i], 1'b0});
      send_tx(lb_byte[i]);
      wait_ready();
      repeat (10) @(negedge clk);
    end
    loop_en = 1'b0;
    repeat (10) @(negedge clk);

    // Same words driven at +-1% baud.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 3; i++) begin
        rx_q.push_back({lb_byte[i], 1'b0});
        send_rx(lb_byte[i], 1'b1, skew_ns[s]);
        repeat (5) @(negedge clk);
      end
    end

    cnt = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("rx_q_drained", rx_q.size(), 32'd0);
    chk("tx_q_drained", tx_q.size(), 32'd0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
